// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for the 8-bit CPU: issues operands to an external ALU, captures result/NZCV, writes back.
// Optional ALU_CTRL_KEEP_CV_EN: logic ops and TST leave C and V untouched.
module alu_exec_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [7:0]  alu_result,
   input  logic [3:0]  alu_nzcv,
   output logic [3:0]  flags,
   output logic        wb_valid,
   output logic [1:0]  wb_rd,
   output logic [7:0]  wb_data,
   input  logic [1:0]  dbg_sel,
   output logic [7:0]  dbg_data
);
   localparam int unsigned NREGS = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned OPW   = 3;
   localparam logic [OPW-1:0] OP_TST = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

   state_t          state;
   logic [DW-1:0]   regs [NREGS];
   logic [3:0]      nzcv_q;
   logic [3:0]      flags_next_c;

   assign dbg_data = regs[dbg_sel];

   // Flag merge applied on the edge leaving WB; alu_op still holds the in-flight op.
   always_comb begin
      flags_next_c = nzcv_q;
`ifdef ALU_CTRL_KEEP_CV_EN
      if (alu_op == 3'b010 || alu_op == 3'b011 || alu_op == 3'b100 || alu_op == OP_TST)
         flags_next_c = {flags[3:2], nzcv_q[1:0]};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         instr_ready <= 1'b1;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= OP_TST;
         flags       <= '0;
         nzcv_q      <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (instr_valid && instr_ready) begin
                  alu_a       <= regs[instr[12:11]];
                  alu_b       <= instr[8] ? instr[7:0] : regs[instr[10:9]];
                  alu_op      <= instr[15:13];
                  wb_rd       <= instr[12:11];
                  instr_ready <= 1'b0;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wb_data  <= alu_result;
               nzcv_q   <= alu_nzcv;
               wb_valid <= 1'b1;
               state    <= S_WB;
            end
            S_WB: begin
               if (alu_op != OP_TST) regs[wb_rd] <= wb_data;
               flags       <= flags_next_c;
               wb_valid    <= 1'b0;
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
            default: begin
               state       <= S_IDLE;
               wb_valid    <= 1'b0;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller that owns the other side of the ALU interface for the 8-bit CPU. It accepts decoded instructions over a valid/ready handshake, reads operands from an internal 4x8 register file and drives the ALU operand and op-code inputs. It then captures the ALU result and NZCV flags, writes the result back and holds the architectural flags register. The ALU itself stays combinational and external; this block sequences it.

## Interface
- NREGS, 4, register-file depth; fixed at 4 because of the 2-bit register fields.
- DW, 8, datapath width; must match the ALU.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept; high only in IDLE.
- instr  in  16  fields: [15:13] op, [12:11] rd, [10:9] rs, [8] use_imm, [7:0] imm.
- alu_a  out  8  ALU operand A, registered.
- alu_b  out  8  ALU operand B, registered.
- alu_op  out  3  ALU op-code, registered.
- alu_result  in  8  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_nzcv  in  4  ALU flags: bit0 N, bit1 Z, bit2 C, bit3 V.
- flags  out  4  architectural flags, same bit order as alu_nzcv.
- wb_valid  out  1  one-cycle pulse during writeback.
- wb_rd  out  2  destination register of current writeback.
- wb_data  out  8  value being written back.
- dbg_sel  in  2  register-file read select.
- dbg_data  out  8  combinational read of reg[dbg_sel].

## Operation
- States: IDLE, ISSUE, WB. Transitions: IDLE->ISSUE on instr_valid&&instr_ready; ISSUE->WB unconditionally; WB->IDLE unconditionally.
- On the accepting edge:
  - alu_a <= reg[rd]
  - alu_b <= use_imm ? imm : reg[rs]
  - alu_op <= op
  - rd is latched
- Op encoding is 1:1 with the ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 TST (pass A).
- End of ISSUE: alu_result is captured into res_q and alu_nzcv into nzcv_q.
- WB:
  - wb_valid=1, wb_rd=latched rd, wb_data=res_q.
  - On the edge leaving WB, reg[rd]<=res_q and flags<=nzcv_q.
  - Exception: op 111 (TST) updates flags only; no register write, but wb_valid still pulses with wb_data=res_q.
- All ops update all four flag bits (subject to Configuration).
- Register reads are always the pre-writeback value. A dbg read of rd during WB returns the old value; the new value is visible from the following cycle.
- No arithmetic is performed in this block. Widths pass straight through, with no extension or truncation.

## Timing
- Reset (async assert, sync-free deassert handled by flop):
  - state=IDLE, instr_ready=1.
  - alu_a=0, alu_b=0, alu_op=3'b111.
  - flags=4'b0000, wb_valid=0, wb_rd=0, wb_data=0.
  - All registers 0.
- Latency:
  - Handshake at edge T0.
  - Operands are valid on alu_* during cycle T0+1 (ISSUE).
  - wb_valid is high during cycle T0+2.
  - Register and flags update at edge T0+3.
- Throughput: one instruction per 3 cycles; instr_ready low for exactly 2 cycles after each accept.
- instr_valid held while busy: no accept, and instr is not sampled, until IDLE.
- Reset asserted in ISSUE or WB: the in-flight instruction is dropped, with no register or flags update; wb_valid drops immediately.
- alu_* inputs are sampled only at the end of ISSUE; values in other cycles are ignored.

## Configuration
- ALU_CTRL_KEEP_CV_EN:
  - Defined: ops 010, 011, 100, 111 update only N and Z; C and V keep their previous values.
  - Undefined: all four flags are taken from alu_nzcv for every op.

## Test plan
- Reset, then release -> instr_ready=1, flags=0, alu_op=3'b111, dbg_data=0 for every dbg_sel.
- OR r0,#0x7F then ADD r0,#0x01 -> wb_data 0x7F then 0x80; final flags=4'b1001 (N=1, V=1); dbg_sel=0 reads 0x80.
- OR r1,#0xFF; ADD r1,#0x01 -> r1=0x00, flags=4'b0110 (Z=1, C=1).
- Carry-preserve case, continuing from the previous sequence: XOR r2,#0x80 -> r2=0x80. Flags become 4'b0101 with ALU_CTRL_KEEP_CV_EN (C kept) and 4'b0001 without it.
- TST r0 with r0=0x00 -> wb_valid pulses, r0 unchanged, Z=1. Separately, instr_valid held high for 4 instructions -> instr_ready high exactly at cycles 0, 3, 6, 9.
- Assert rst_n=0 during ISSUE of ADD r3,#0x05 -> no wb_valid, r3=0, flags=0, state IDLE after release.
